uart_rx_frame: RTL

//  Receive side of the board UART link. Decodes 11-bit serial frames on rx:

---
 rtl/uart_rx_frame.sv | 136 +++++++++++++
 1 files changed

// File: rtl/uart_rx_frame.sv
// UART receive framer: start, DATA_BITS data (LSB first), optional parity, stop.
// Each byte is presented with a one-cycle valid strobe and held error flags.
module uart_rx_frame #(
    parameter int DELAY_COUNTS = 5210,
    parameter int HALF_COUNTS  = 2605,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 rx_busy
);
    // State     | meaning
    // S_IDLE    | line idle, waiting for a falling edge
    // S_START   | timing to the start-bit centre, glitch check
    // S_DATA    | sampling data bits at bit centres
    // S_PARITY  | sampling the parity bit
    // S_STOP    | sampling the stop bit, publishing the byte
    // S_WAIT_IDLE | break/framing error, waiting for line to return high

    localparam int CNT_W = $clog2(DELAY_COUNTS);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(DELAY_COUNTS - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_COUNTS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic PAR_EN  = (PARITY_EN != 0);
    localparam logic PAR_ODD = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t               state;
    logic [1:0]           sync;
    logic                 rx_s;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bit;

    assign rx_s = sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            sync       <= 2'b11;
            cnt        <= '0;
            idx        <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            rx_busy    <= 1'b0;
        end else begin
            sync     <= {sync[0], rx};
            rx_valid <= 1'b0;
            cnt      <= cnt + 1'b1;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state   <= S_START;
                        rx_busy <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt == HALF_END) begin
                        cnt <= '0;
                        idx <= '0;
                        if (rx_s) begin
                            state   <= S_IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (cnt == BIT_END) begin
                        cnt   <= '0;
                        shift <= {rx_s, shift[DATA_BITS-1:1]};
                        if (idx == LAST_IDX) begin
                            state <= PAR_EN ? S_PARITY : S_STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (cnt == BIT_END) begin
                        cnt     <= '0;
                        par_bit <= rx_s;
                        state   <= S_STOP;
                    end
                end
                S_STOP: begin
                    // Leaving at the stop-bit centre lets a back-to-back start edge be caught.
                    if (cnt == BIT_END) begin
                        cnt        <= '0;
                        rx_data    <= shift;
                        rx_valid   <= 1'b1;
                        parity_err <= PAR_EN ? (^shift ^ par_bit ^ PAR_ODD) : 1'b0;
                        frame_err  <= ~rx_s;
                        state      <= rx_s ? S_IDLE : S_WAIT_IDLE;
                        rx_busy    <= ~rx_s;
                    end
                end
                S_WAIT_IDLE: begin
                    cnt <= '0;
                    if (rx_s) begin
                        state   <= S_IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    cnt     <= '0;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
